// File: rtl/lru_way_alloc.sv
// rtl/lru_way_alloc.sv - LRU slot allocator for a small fully-associative buffer
// Tracks slot validity and LRU->MRU order; grants fill slots through a one-deep response register.
module lru_way_alloc #(
  parameter int NUM_WAYS = 4,
  parameter int IDXW     = $clog2(NUM_WAYS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            touch_valid,
  input  logic [IDXW-1:0] touch_idx,
  input  logic            inval_valid,
  input  logic [IDXW-1:0] inval_idx,
  input  logic            alloc_valid,
  output logic            alloc_ready,
  output logic            rsp_valid,
  output logic [IDXW-1:0] rsp_idx,
  output logic            rsp_evict,
  input  logic            rsp_ready,
  output logic [IDXW-1:0] lru_idx,
  output logic [IDXW:0]   num_valid,
  output logic            full
);

  localparam logic [IDXW:0] FULL_CNT = (IDXW+1)'(NUM_WAYS);
  localparam logic [IDXW:0] ONE      = (IDXW+1)'(1);

  logic [NUM_WAYS-1:0][IDXW-1:0] order_q, order_d, ord_t, ord_i;
  logic [NUM_WAYS-1:0]           valid_q, valid_d;
  logic [IDXW:0]                 num_valid_q, num_valid_d;
  logic                          rsp_valid_q, rsp_valid_d;
  logic [IDXW-1:0]               rsp_idx_q, rsp_idx_d;
  logic                          rsp_evict_q, rsp_evict_d;

  logic            touch_hit, inval_hit, alloc_acc;
  logic            seen_t, seen_i;
  logic [IDXW-1:0] victim;
  logic            victim_live;

  assign touch_hit   = touch_valid & valid_q[touch_idx];
  assign inval_hit   = inval_valid & valid_q[inval_idx];
  assign alloc_ready = (~rsp_valid_q | rsp_ready) & ~inval_valid;
  assign alloc_acc   = alloc_valid & alloc_ready;

  always_comb begin
    // Touch: entries above the hit slot slide down, hit slot goes to MRU.
    ord_t  = order_q;
    seen_t = 1'b0;
    if (touch_hit) begin
      for (int i = 0; i < NUM_WAYS-1; i++) begin
        seen_t = seen_t | (order_q[i] == touch_idx);
        if (seen_t) ord_t[i] = order_q[i+1];
      end
      ord_t[NUM_WAYS-1] = touch_idx;
    end

    // Inval sees the post-touch order so a colliding touch loses.
    ord_i  = ord_t;
    seen_i = 1'b0;
    if (inval_hit) begin
      for (int i = NUM_WAYS-1; i > 0; i--) begin
        seen_i = seen_i | (ord_t[i] == inval_idx);
        if (seen_i) ord_i[i] = ord_t[i-1];
      end
      ord_i[0] = inval_idx;
    end

    valid_d     = valid_q;
    num_valid_d = num_valid_q;
    if (inval_hit) begin
      valid_d[inval_idx] = 1'b0;
      num_valid_d        = num_valid_q - ONE;
    end

    victim      = ord_i[0];
    victim_live = valid_d[victim];
    order_d     = ord_i;
    rsp_idx_d   = rsp_idx_q;
    rsp_evict_d = rsp_evict_q;
    rsp_valid_d = rsp_valid_q & ~rsp_ready;

    if (alloc_acc) begin
      for (int i = 0; i < NUM_WAYS-1; i++) begin
        order_d[i] = ord_i[i+1];
      end
      order_d[NUM_WAYS-1] = victim;
      valid_d[victim]     = 1'b1;
      if (!victim_live) num_valid_d = num_valid_q + ONE;
      rsp_valid_d = 1'b1;
      rsp_idx_d   = victim;
      rsp_evict_d = victim_live;
    end

    if (reset) begin
      for (int i = 0; i < NUM_WAYS; i++) begin
        order_d[i] = IDXW'(i);
      end
      valid_d     = '0;
      num_valid_d = '0;
      rsp_valid_d = 1'b0;
      rsp_idx_d   = '0;
      rsp_evict_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    order_q     <= order_d;
    valid_q     <= valid_d;
    num_valid_q <= num_valid_d;
    rsp_valid_q <= rsp_valid_d;
    rsp_idx_q   <= rsp_idx_d;
    rsp_evict_q <= rsp_evict_d;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_idx   = rsp_idx_q;
  assign rsp_evict = rsp_evict_q;
  assign lru_idx   = order_q[0];
  assign num_valid = num_valid_q;
  assign full      = (num_valid_q == FULL_CNT);

endmodule

// File: tb/tb_lru_way_alloc.sv
// tb/tb_lru_way_alloc.sv - self-checking bench for lru_way_alloc
// Queue-based reference model checked every cycle, plus hand-computed directed expectations.
module tb_lru_way_alloc;

  localparam int NUM_WAYS = 4;
  localparam int IDXW     = 2;

  logic            clk;
  logic            reset;
  logic            touch_valid;
  logic [IDXW-1:0] touch_idx;
  logic            inval_valid;
  logic [IDXW-1:0] inval_idx;
  logic            alloc_valid;
  logic            alloc_ready;
  logic            rsp_valid;
  logic [IDXW-1:0] rsp_idx;
  logic            rsp_evict;
  logic            rsp_ready;
  logic [IDXW-1:0] lru_idx;
  logic [IDXW:0]   num_valid;
  logic            full;

  lru_way_alloc #(.NUM_WAYS(NUM_WAYS), .IDXW(IDXW)) dut (
    .clk         (clk),
    .reset       (reset),
    .touch_valid (touch_valid),
    .touch_idx   (touch_idx),
    .inval_valid (inval_valid),
    .inval_idx   (inval_idx),
    .alloc_valid (alloc_valid),
    .alloc_ready (alloc_ready),
    .rsp_valid   (rsp_valid),
    .rsp_idx     (rsp_idx),
    .rsp_evict   (rsp_evict),
    .rsp_ready   (rsp_ready),
    .lru_idx     (lru_idx),
    .num_valid   (num_valid),
    .full        (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: queue front is LRU, back is MRU.
  int mq[$];
  bit mv[NUM_WAYS];
  int mnum;
  bit m_rv;
  int m_ri;
  bit m_re;
  bit m_acc;
  int m_vic;

  function automatic void mremove(int s);
    for (int k = 0; k < mq.size(); k++) begin
      if (mq[k] == s) begin
        mq.delete(k);
        break;
      end
    end
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mq = {};
      for (int k = 0; k < NUM_WAYS; k++) begin
        mq.push_back(k);
        mv[k] = 1'b0;
      end
      mnum = 0;
      m_rv = 1'b0;
      m_ri = 0;
      m_re = 1'b0;
    end else begin
      m_acc = alloc_valid && (!m_rv || rsp_ready) && !inval_valid;
      if (touch_valid && mv[touch_idx]) begin
        mremove(int'(touch_idx));
        mq.push_back(int'(touch_idx));
      end
      if (inval_valid && mv[inval_idx]) begin
        mremove(int'(inval_idx));
        mq.push_front(int'(inval_idx));
        mv[inval_idx] = 1'b0;
        mnum--;
      end
      if (m_acc) begin
        m_vic = mq.pop_front();
        mq.push_back(m_vic);
        m_re = mv[m_vic];
        m_ri = m_vic;
        if (!mv[m_vic]) mnum++;
        mv[m_vic] = 1'b1;
        m_rv = 1'b1;
      end else if (rsp_ready) begin
        m_rv = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_lru_idx", int'(lru_idx), mq[0]);
      chk("m_num_valid", int'(num_valid), mnum);
      chk("m_full", int'(full), int'(mnum == NUM_WAYS));
      chk("m_alloc_ready", int'(alloc_ready), int'((!m_rv || rsp_ready) && !inval_valid));
      chk("m_rsp_valid", int'(rsp_valid), int'(m_rv));
      if (m_rv) begin
        chk("m_rsp_idx", int'(rsp_idx), m_ri);
        chk("m_rsp_evict", int'(rsp_evict), int'(m_re));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; touch_valid = 1'b0; touch_idx = '0; inval_valid = 1'b0;
    inval_idx = '0; alloc_valid = 1'b0; rsp_ready = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_lru", int'(lru_idx), 0);
    chk("rst_num", int'(num_valid), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_alloc_ready", int'(alloc_ready), 1);

    // Fill from empty
    alloc_valid = 1'b1;
    for (int k = 0; k < NUM_WAYS; k++) begin
      step();
      chk("fill_rsp_valid", int'(rsp_valid), 1);
      chk("fill_idx", int'(rsp_idx), k);
      chk("fill_evict", int'(rsp_evict), 0);
    end
    alloc_valid = 1'b0;
    step();
    chk("fill_num", int'(num_valid), 4);
    chk("fill_full", int'(full), 1);
    chk("fill_lru", int'(lru_idx), 0);
    chk("fill_rsp_drop", int'(rsp_valid), 0);

    // Eviction with a concurrent touch of the LRU
    touch_valid = 1'b1; touch_idx = 2'd0; alloc_valid = 1'b1;
    step();
    touch_valid = 1'b0;
    chk("evt_idx", int'(rsp_idx), 1);
    chk("evt_evict", int'(rsp_evict), 1);
    step();
    alloc_valid = 1'b0;
    chk("evt2_idx", int'(rsp_idx), 2);
    chk("evt2_evict", int'(rsp_evict), 1);
    step();
    chk("evt_lru", int'(lru_idx), 3);
    chk("evt_num", int'(num_valid), 4);

    // Inval of the MRU then refill
    inval_valid = 1'b1; inval_idx = 2'd2;
    step();
    inval_valid = 1'b0;
    chk("inv_lru", int'(lru_idx), 2);
    chk("inv_num", int'(num_valid), 3);
    chk("inv_full", int'(full), 0);
    alloc_valid = 1'b1;
    step();
    alloc_valid = 1'b0;
    chk("refill_idx", int'(rsp_idx), 2);
    chk("refill_evict", int'(rsp_evict), 0);
    step();
    chk("refill_num", int'(num_valid), 4);
    chk("refill_lru", int'(lru_idx), 3);

    // Backpressure
    rsp_ready = 1'b0; alloc_valid = 1'b1;
    step();
    chk("bp_idx", int'(rsp_idx), 3);
    chk("bp_evict", int'(rsp_evict), 1);
    chk("bp_ready", int'(alloc_ready), 0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_hold_valid", int'(rsp_valid), 1);
      chk("bp_hold_idx", int'(rsp_idx), 3);
      chk("bp_hold_evict", int'(rsp_evict), 1);
      chk("bp_hold_ready", int'(alloc_ready), 0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", int'(alloc_ready), 1);
    step();
    chk("bp_next_valid", int'(rsp_valid), 1);
    chk("bp_next_idx", int'(rsp_idx), 0);
    chk("bp_next_evict", int'(rsp_evict), 1);

    // Inval in flight blocks alloc regardless of response state
    inval_valid = 1'b1; inval_idx = 2'd0;
    #1;
    chk("inv_block_rdy1", int'(alloc_ready), 0);
    rsp_ready = 1'b0;
    #1;
    chk("inv_block_rdy0", int'(alloc_ready), 0);
    rsp_ready = 1'b1; inval_valid = 1'b0; alloc_valid = 1'b0;
    step();
    chk("drain_rsp_valid", int'(rsp_valid), 0);
    chk("drain_num", int'(num_valid), 4);

    // Touch/inval collision, then ignored ops (order is 1,2,3,0)
    touch_valid = 1'b1; touch_idx = 2'd1; inval_valid = 1'b1; inval_idx = 2'd1;
    step();
    inval_valid = 1'b0;
    chk("col_lru", int'(lru_idx), 1);
    chk("col_num", int'(num_valid), 3);
    chk("col_full", int'(full), 0);
    step();
    touch_valid = 1'b0; inval_valid = 1'b1;
    chk("ign_touch_lru", int'(lru_idx), 1);
    chk("ign_touch_num", int'(num_valid), 3);
    step();
    inval_valid = 1'b0; touch_valid = 1'b1; touch_idx = 2'd0;
    chk("ign_inval_num", int'(num_valid), 3);
    step();
    touch_valid = 1'b0;
    chk("mru_touch_lru", int'(lru_idx), 1);

    // Reset with a pending response
    inval_valid = 1'b1; inval_idx = 2'd2;
    step();
    inval_valid = 1'b0;
    chk("pre_rst_lru", int'(lru_idx), 2);
    chk("pre_rst_num", int'(num_valid), 2);
    rsp_ready = 1'b0; alloc_valid = 1'b1;
    step();
    alloc_valid = 1'b0;
    chk("pre_rst_valid", int'(rsp_valid), 1);
    chk("pre_rst_idx", int'(rsp_idx), 2);
    chk("pre_rst_evict", int'(rsp_evict), 0);
    chk("pre_rst_num3", int'(num_valid), 3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("post_rst_valid", int'(rsp_valid), 0);
    chk("post_rst_num", int'(num_valid), 0);
    chk("post_rst_lru", int'(lru_idx), 0);
    alloc_valid = 1'b1; rsp_ready = 1'b1;
    step();
    alloc_valid = 1'b0;
    chk("post_rst_alloc_idx", int'(rsp_idx), 0);
    chk("post_rst_alloc_evict", int'(rsp_evict), 0);
    chk("post_rst_alloc_valid", int'(rsp_valid), 1);
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
